// File: rtl/evit_213_pkg.sv
// Shared definitions for the (2,1,3) Viterbi frame sequencer: code constants,
// default frame geometry and the sequencer state encoding.
package evit_213_pkg;

  localparam int K             = 3;
  localparam int TAIL_LEN_DEF  = K - 1;
  localparam int FRAME_LEN_DEF = 16;
  localparam int ADDR_W_DEF    = 5;
  localparam int CNT_W_DEF     = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_TRACE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/evit_sym_pipe_213.sv
// Two-stage symbol delay line: accept strobe -> BMU load (stage 1) -> ACS and
// survivor-memory write (stage 2).
module evit_sym_pipe_213 (
  input  logic       clock,
  input  logic       reset,
  input  logic       accept,
  input  logic [1:0] sym,
  output logic       bmu_le,
  output logic [1:0] bmu_rx,
  output logic       acs_en,
  output logic       sm_wr_en
);

  logic       le_r;
  logic [1:0] rx_r;
  logic       acs_r;

  // Delay line registers; the BMU symbol holds its last accepted value.
  always_ff @(posedge clock) begin
    if (reset) begin
      le_r  <= 1'b0;
      rx_r  <= 2'b00;
      acs_r <= 1'b0;
    end else begin
      le_r  <= accept;
      acs_r <= le_r;
      if (accept) begin
        rx_r <= sym;
      end else begin
        rx_r <= rx_r;
      end
    end
  end

  assign bmu_le   = le_r;
  assign bmu_rx   = rx_r;
  assign acs_en   = acs_r;
  assign sm_wr_en = acs_r;

endmodule

// File: rtl/evit_ctrl_213.sv
// Frame sequencer: accepts FRAME_LEN+TAIL_LEN symbols, drives BMU/ACS/survivor
// writes through the symbol pipe, then launches one traceback per frame.
module evit_ctrl_213
  import evit_213_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int TAIL_LEN  = TAIL_LEN_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [1:0]        in_sym,
  output logic              in_ready,
  output logic [1:0]        bmu_rx,
  output logic              bmu_le,
  output logic              acs_init,
  output logic              acs_en,
  output logic              sm_wr_en,
  output logic [ADDR_W-1:0] sm_wr_addr,
  output logic              tb_start,
  output logic [ADDR_W-1:0] tb_addr,
  input  logic              tb_done,
  output logic              busy,
  output logic              frame_done
);

  localparam int TOTAL = FRAME_LEN + TAIL_LEN;
  localparam logic [CNT_W-1:0] TOTAL_CNT = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TOTAL - 1);

  state_e             state_r, state_s;
  logic [CNT_W-1:0]   sym_cnt_r, sym_cnt_s;
  logic [ADDR_W-1:0]  wr_addr_r, sm_wr_addr_r, tb_addr_r;
  logic               in_ready_r, in_ready_s;
  logic               acs_init_r, tb_start_r, busy_r, frame_done_r;
  logic               accept_s, bmu_le_s;

  assign accept_s = in_valid && in_ready_r;

  evit_sym_pipe_213 u_pipe (
    .clock    (clock),
    .reset    (reset),
    .accept   (accept_s),
    .sym      (in_sym),
    .bmu_le   (bmu_le_s),
    .bmu_rx   (bmu_rx),
    .acs_en   (acs_en),
    .sm_wr_en (sm_wr_en)
  );

  // Next-state, symbol count and next in_ready.
  always_comb begin
    state_s   = state_r;
    sym_cnt_s = sym_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_s = ST_INIT;
        else       state_s = ST_IDLE;
      end
      ST_INIT: begin
        sym_cnt_s = '0;
        state_s   = ST_RUN;
      end
      ST_RUN: begin
        if (accept_s) begin
          sym_cnt_s = sym_cnt_r + CNT_W'(1);
          if (sym_cnt_r == LAST_CNT) state_s = ST_DRAIN;
          else                       state_s = ST_RUN;
        end else begin
          state_s = ST_RUN;
        end
      end
      // Stage 1 empty means the final ACS/survivor write issues this cycle.
      ST_DRAIN: begin
        if (!bmu_le_s) state_s = ST_TRACE;
        else           state_s = ST_DRAIN;
      end
      ST_TRACE: begin
        if (tb_done) state_s = ST_DONE;
        else         state_s = ST_TRACE;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
    in_ready_s = (state_s == ST_RUN) && (sym_cnt_s < TOTAL_CNT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      sym_cnt_r    <= '0;
      wr_addr_r    <= '0;
      sm_wr_addr_r <= '0;
      tb_addr_r    <= '0;
      in_ready_r   <= 1'b0;
      acs_init_r   <= 1'b0;
      tb_start_r   <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      sym_cnt_r    <= sym_cnt_s;
      in_ready_r   <= in_ready_s;
      acs_init_r   <= (state_s == ST_INIT);
      busy_r       <= (state_s != ST_IDLE);
      frame_done_r <= (state_s == ST_DONE);
      tb_start_r   <= (state_s == ST_TRACE) && (state_r != ST_TRACE);
      if (state_r == ST_INIT) begin
        wr_addr_r <= '0;
      end else if (bmu_le_s) begin
        sm_wr_addr_r <= wr_addr_r;
        wr_addr_r    <= wr_addr_r + ADDR_W'(1);
      end else begin
        wr_addr_r <= wr_addr_r;
      end
      if ((state_s == ST_TRACE) && (state_r != ST_TRACE)) begin
        tb_addr_r <= sm_wr_addr_r;
      end else begin
        tb_addr_r <= tb_addr_r;
      end
    end
  end

  assign in_ready   = in_ready_r;
  assign bmu_le     = bmu_le_s;
  assign acs_init   = acs_init_r;
  assign sm_wr_addr = sm_wr_addr_r;
  assign tb_start   = tb_start_r;
  assign tb_addr    = tb_addr_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

endmodule
